// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the boot/debug loader and the data RAM.
// The arbiter is the slave side; whoever drives the requesters and models the RAM uses master.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  // core request / response
  logic                  core_req_valid;
  logic                  core_req_ready;
  logic                  core_req_we;
  logic [ADDR_WIDTH+1:0] core_req_addr;
  logic [1:0]            core_req_size;
  logic                  core_req_unsigned;
  logic [31:0]           core_req_wdata;
  logic                  core_rsp_valid;
  logic                  core_rsp_err;
  logic [31:0]           core_rsp_rdata;

  // loader request / response
  logic                  ldr_req_valid;
  logic                  ldr_req_ready;
  logic                  ldr_req_we;
  logic [ADDR_WIDTH-1:0] ldr_req_addr;
  logic [3:0]            ldr_req_wstrb;
  logic [31:0]           ldr_req_wdata;
  logic                  ldr_rsp_valid;
  logic [31:0]           ldr_rsp_rdata;

  // data RAM port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data_in;
  logic                  mem_we;
  logic                  mem_re;
  logic [3:0]            mem_byte_sel;
  logic [31:0]           mem_data_out;

  modport slave (
    input  core_req_valid, core_req_we, core_req_addr, core_req_size,
           core_req_unsigned, core_req_wdata,
    output core_req_ready, core_rsp_valid, core_rsp_err, core_rsp_rdata,
    input  ldr_req_valid, ldr_req_we, ldr_req_addr, ldr_req_wstrb, ldr_req_wdata,
    output ldr_req_ready, ldr_rsp_valid, ldr_rsp_rdata,
    output mem_addr, mem_data_in, mem_we, mem_re, mem_byte_sel,
    input  mem_data_out
  );

  modport master (
    output core_req_valid, core_req_we, core_req_addr, core_req_size,
           core_req_unsigned, core_req_wdata,
    input  core_req_ready, core_rsp_valid, core_rsp_err, core_rsp_rdata,
    output ldr_req_valid, ldr_req_we, ldr_req_addr, ldr_req_wstrb, ldr_req_wdata,
    input  ldr_req_ready, ldr_rsp_valid, ldr_rsp_rdata,
    input  mem_addr, mem_data_in, mem_we, mem_re, mem_byte_sel,
    output mem_data_out
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter between the core MEM stage and the loader for a 4-lane data RAM,
// with core store alignment, misalignment detection and load extraction/extension.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_port_arbiter_if.slave   bus
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LANES      = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic       is_load;
    logic [1:0] size;
    logic [1:0] off;
    logic       uns;
    logic       err;
  } pend_t;

  owner_e last_grant_q, last_grant_d;
  pend_t  pend_q, pend_d;

  logic grant_core;
  logic grant_ldr;

  logic [1:0]            core_off;
  logic                  core_err;
  logic [LANES-1:0]      core_sel;
  logic [DATA_WIDTH-1:0] core_wdata_al;

  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_data_in_c;
  logic                  mem_we_c;
  logic                  mem_re_c;
  logic [LANES-1:0]      mem_byte_sel_c;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  logic                  core_rsp_valid_c;
  logic                  ldr_rsp_valid_c;

  // State register: grant history and the one-deep response pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_LDR;
      pend_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
    end
  end

  // Grant: a lone requester wins; on conflict the one not granted last time wins
  always_comb begin
    grant_core = 1'b0;
    grant_ldr  = 1'b0;
    if (rst_n) begin
      if (bus.core_req_valid && bus.ldr_req_valid) begin
        if (last_grant_q == OWN_LDR) grant_core = 1'b1;
        else                         grant_ldr  = 1'b1;
      end else if (bus.core_req_valid) begin
        grant_core = 1'b1;
      end else if (bus.ldr_req_valid) begin
        grant_ldr = 1'b1;
      end
    end
  end

  // Core lane select, store data replication and alignment check
  always_comb begin
    core_off      = bus.core_req_addr[1:0];
    core_err      = 1'b0;
    core_sel      = '0;
    core_wdata_al = bus.core_req_wdata;
    case (bus.core_req_size)
      SZ_BYTE: begin
        core_sel      = LANES'(4'b0001 << core_off);
        core_wdata_al = {4{bus.core_req_wdata[7:0]}};
      end
      SZ_HALF: begin
        core_err      = core_off[0];
        core_sel      = core_off[1] ? 4'b1100 : 4'b0011;
        core_wdata_al = {2{bus.core_req_wdata[15:0]}};
      end
      SZ_WORD: begin
        core_err = (core_off != 2'b00);
        core_sel = 4'b1111;
      end
      default: begin
        core_err = 1'b1;
      end
    endcase
  end

  // Next state: grant history, pending capture and the RAM command of the winner
  always_comb begin
    last_grant_d   = last_grant_q;
    pend_d         = '0;
    mem_addr_c     = '0;
    mem_data_in_c  = '0;
    mem_we_c       = 1'b0;
    mem_re_c       = 1'b0;
    mem_byte_sel_c = '0;

    if (grant_core) begin
      last_grant_d   = OWN_CORE;
      pend_d.valid   = 1'b1;
      pend_d.owner   = OWN_CORE;
      pend_d.is_load = !bus.core_req_we;
      pend_d.size    = bus.core_req_size;
      pend_d.off     = core_off;
      pend_d.uns     = bus.core_req_unsigned;
      pend_d.err     = core_err;
      mem_addr_c     = bus.core_req_addr[ADDR_WIDTH+1:2];
      mem_data_in_c  = core_wdata_al;
      if (!core_err) begin
        if (bus.core_req_we) begin
          mem_we_c       = 1'b1;
          mem_byte_sel_c = core_sel;
        end else begin
          mem_re_c       = 1'b1;
          mem_byte_sel_c = 4'b1111;
        end
      end
    end else if (grant_ldr) begin
      last_grant_d   = OWN_LDR;
      pend_d.valid   = 1'b1;
      pend_d.owner   = OWN_LDR;
      pend_d.is_load = !bus.ldr_req_we;
      mem_addr_c     = bus.ldr_req_addr;
      mem_data_in_c  = bus.ldr_req_wdata;
      if (bus.ldr_req_we) begin
        mem_we_c       = 1'b1;
        mem_byte_sel_c = bus.ldr_req_wstrb;
      end else begin
        mem_re_c       = 1'b1;
        mem_byte_sel_c = 4'b1111;
      end
    end
  end

  // Load extraction from the RAM word returned for the pending access
  always_comb begin
    case (pend_q.off)
      2'b00:   ld_byte = bus.mem_data_out[7:0];
      2'b01:   ld_byte = bus.mem_data_out[15:8];
      2'b10:   ld_byte = bus.mem_data_out[23:16];
      default: ld_byte = bus.mem_data_out[31:24];
    endcase
    ld_half = pend_q.off[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
    case (pend_q.size)
      SZ_BYTE: ld_ext = pend_q.uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = pend_q.uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      SZ_WORD: ld_ext = bus.mem_data_out;
      default: ld_ext = '0;
    endcase
  end

  assign core_rsp_valid_c = pend_q.valid && (pend_q.owner == OWN_CORE);
  assign ldr_rsp_valid_c  = pend_q.valid && (pend_q.owner == OWN_LDR);

  assign bus.core_req_ready = grant_core;
  assign bus.ldr_req_ready  = grant_ldr;

  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_data_in  = mem_data_in_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_re       = mem_re_c;
  assign bus.mem_byte_sel = mem_byte_sel_c;

  assign bus.core_rsp_valid = core_rsp_valid_c;
  assign bus.core_rsp_err   = core_rsp_valid_c && pend_q.err;
  assign bus.core_rsp_rdata = (core_rsp_valid_c && pend_q.is_load && !pend_q.err) ? ld_ext : '0;

  assign bus.ldr_rsp_valid  = ldr_rsp_valid_c;
  assign bus.ldr_rsp_rdata  = (ldr_rsp_valid_c && pend_q.is_load) ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed vector bench for dmem_port_arbiter with a write-first, 1-cycle-latency RAM model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 9;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam int unsigned NVEC = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: lane-enabled writes, registered read
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_byte_sel[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_data_in[8*i +: 8];
    end
    if (bus.mem_re) bus.mem_data_out <= ram[bus.mem_addr];
  end

  typedef struct {
    logic cv; logic cwe; logic [10:0] caddr; logic [1:0] csz; logic cuns; logic [31:0] cwd;
    logic lv; logic lwe; logic [8:0] laddr; logic [3:0] lstrb; logic [31:0] lwd;
    logic e_crdy; logic e_lrdy; logic e_we; logic e_re; logic [3:0] e_sel; logic [8:0] e_addr; logic [31:0] e_din;
    logic e_crv; logic e_cerr; logic [31:0] e_crd; logic e_lrv; logic [31:0] e_lrd;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.core_req_valid    = v.cv;
    bus.core_req_we       = v.cwe;
    bus.core_req_addr     = v.caddr;
    bus.core_req_size     = v.csz;
    bus.core_req_unsigned = v.cuns;
    bus.core_req_wdata    = v.cwd;
    bus.ldr_req_valid     = v.lv;
    bus.ldr_req_we        = v.lwe;
    bus.ldr_req_addr      = v.laddr;
    bus.ldr_req_wstrb     = v.lstrb;
    bus.ldr_req_wdata     = v.lwd;
  endtask

  task automatic idle();
    bus.core_req_valid = 1'b0;
    bus.core_req_we    = 1'b0;
    bus.ldr_req_valid  = 1'b0;
    bus.ldr_req_we     = 1'b0;
  endtask

  task automatic both_loads();
    bus.core_req_valid = 1'b1; bus.core_req_we = 1'b0; bus.core_req_addr = 11'h010;
    bus.core_req_size  = 2'd2; bus.core_req_unsigned = 1'b0;
    bus.ldr_req_valid  = 1'b1; bus.ldr_req_we = 1'b0; bus.ldr_req_addr = 9'd4;
  endtask

  initial begin
    //           cv cwe caddr    csz   cuns cwd           lv lwe laddr lstrb lwd           crdy lrdy we re sel   addr  din           crv cerr crd           lrv lrd
    vecs[0]  = '{Y, Y, 11'h010, 2'd2, N, 32'hDEADBEEF, N, N, 9'd0, 4'h0, 32'h0,        Y, N, Y, N, 4'hF, 9'd4, 32'hDEADBEEF, N, N, 32'h0,        N, 32'h0};
    vecs[1]  = '{Y, N, 11'h013, 2'd0, Y, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        Y, N, 32'h0,        N, 32'h0};
    vecs[2]  = '{Y, N, 11'h012, 2'd1, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        Y, N, 32'h000000DE, N, 32'h0};
    vecs[3]  = '{Y, N, 11'h012, 2'd1, Y, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        Y, N, 32'hFFFFDEAD, N, 32'h0};
    vecs[4]  = '{Y, Y, 11'h011, 2'd0, N, 32'h0000007F, N, N, 9'd0, 4'h0, 32'h0,        Y, N, Y, N, 4'h2, 9'd4, 32'h7F7F7F7F, Y, N, 32'h0000DEAD, N, 32'h0};
    vecs[5]  = '{Y, N, 11'h013, 2'd0, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        Y, N, 32'h0,        N, 32'h0};
    vecs[6]  = '{Y, N, 11'h011, 2'd0, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        Y, N, 32'hFFFFFFDE, N, 32'h0};
    vecs[7]  = '{Y, N, 11'h010, 2'd2, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        Y, N, 32'h0000007F, N, 32'h0};
    vecs[8]  = '{Y, N, 11'h006, 2'd2, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, N, 4'h0, 9'd0, 32'h0,        Y, N, 32'hDEAD7FEF, N, 32'h0};
    vecs[9]  = '{Y, N, 11'h010, 2'd3, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, N, 4'h0, 9'd0, 32'h0,        Y, Y, 32'h0,        N, 32'h0};
    vecs[10] = '{Y, Y, 11'h011, 2'd1, N, 32'hDEADBEEF, N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, N, 4'h0, 9'd0, 32'h0,        Y, Y, 32'h0,        N, 32'h0};
    vecs[11] = '{Y, Y, 11'h012, 2'd1, N, 32'h0000CAFE, N, N, 9'd0, 4'h0, 32'h0,        Y, N, Y, N, 4'hC, 9'd4, 32'hCAFECAFE, Y, Y, 32'h0,        N, 32'h0};
    vecs[12] = '{N, N, 11'h000, 2'd0, N, 32'h0,        Y, Y, 9'd5, 4'hF, 32'hAABBCCDD, N, Y, Y, N, 4'hF, 9'd5, 32'hAABBCCDD, Y, N, 32'h0,        N, 32'h0};
    vecs[13] = '{N, N, 11'h000, 2'd0, N, 32'h0,        Y, Y, 9'd5, 4'h5, 32'h11223344, N, Y, Y, N, 4'h5, 9'd5, 32'h11223344, N, N, 32'h0,        Y, 32'h0};
    vecs[14] = '{N, N, 11'h000, 2'd0, N, 32'h0,        Y, N, 9'd5, 4'h0, 32'h0,        N, Y, N, Y, 4'hF, 9'd5, 32'h0,        N, N, 32'h0,        Y, 32'h0};
    vecs[15] = '{N, N, 11'h000, 2'd0, N, 32'h0,        Y, Y, 9'd5, 4'h0, 32'hFFFFFFFF, N, Y, Y, N, 4'h0, 9'd5, 32'hFFFFFFFF, N, N, 32'h0,        Y, 32'hAA22CC44};
    vecs[16] = '{N, N, 11'h000, 2'd0, N, 32'h0,        Y, N, 9'd5, 4'h0, 32'h0,        N, Y, N, Y, 4'hF, 9'd5, 32'h0,        N, N, 32'h0,        Y, 32'h0};
    vecs[17] = '{Y, N, 11'h010, 2'd2, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        Y, N, N, Y, 4'hF, 9'd4, 32'h0,        N, N, 32'h0,        Y, 32'hAA22CC44};
    vecs[18] = '{N, N, 11'h000, 2'd0, N, 32'h0,        N, N, 9'd0, 4'h0, 32'h0,        N, N, N, N, 4'h0, 9'd0, 32'h0,        Y, N, 32'hCAFE7FEF, N, 32'h0};

    // Reset state, with a core store presented so forced-low outputs are observable
    drive(vecs[0]);
    #1;
    chk("reset core_ready", 32'(bus.core_req_ready), 32'h0);
    chk("reset ldr_ready",  32'(bus.ldr_req_ready),  32'h0);
    chk("reset mem_we",     32'(bus.mem_we),         32'h0);
    chk("reset core_rsp_valid", 32'(bus.core_rsp_valid), 32'h0);
    chk("reset ldr_rsp_valid",  32'(bus.ldr_rsp_valid),  32'h0);
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d core_ready", i), 32'(bus.core_req_ready), 32'(vecs[i].e_crdy));
      chk($sformatf("v%0d ldr_ready", i),  32'(bus.ldr_req_ready),  32'(vecs[i].e_lrdy));
      chk($sformatf("v%0d mem_we", i),     32'(bus.mem_we),         32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_re", i),     32'(bus.mem_re),         32'(vecs[i].e_re));
      chk($sformatf("v%0d mem_byte_sel", i), 32'(bus.mem_byte_sel), 32'(vecs[i].e_sel));
      if (vecs[i].e_we || vecs[i].e_re)
        chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we)
        chk($sformatf("v%0d mem_data_in", i), bus.mem_data_in, vecs[i].e_din);
      chk($sformatf("v%0d core_rsp_valid", i), 32'(bus.core_rsp_valid), 32'(vecs[i].e_crv));
      chk($sformatf("v%0d core_rsp_err", i),   32'(bus.core_rsp_err),   32'(vecs[i].e_cerr));
      chk($sformatf("v%0d core_rsp_rdata", i), bus.core_rsp_rdata,      vecs[i].e_crd);
      chk($sformatf("v%0d ldr_rsp_valid", i),  32'(bus.ldr_rsp_valid),  32'(vecs[i].e_lrv));
      chk($sformatf("v%0d ldr_rsp_rdata", i),  bus.ldr_rsp_rdata,       vecs[i].e_lrd);
    end

    // Both requesters valid for 4 cycles from reset: grants alternate C, L, C, L
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) both_loads();
      else       idle();
      #1;
      if (k < 4) begin
        chk($sformatf("rr%0d core_ready", k), 32'(bus.core_req_ready), 32'((k % 2) == 0));
        chk($sformatf("rr%0d ldr_ready", k),  32'(bus.ldr_req_ready),  32'((k % 2) == 1));
      end
      chk($sformatf("rr%0d core_rsp_valid", k), 32'(bus.core_rsp_valid), 32'((k % 2) == 1));
      chk($sformatf("rr%0d ldr_rsp_valid", k),  32'(bus.ldr_rsp_valid),  32'(k > 0 && (k % 2) == 0));
      if (k > 0) begin
        if ((k % 2) == 1) chk($sformatf("rr%0d core_rsp_rdata", k), bus.core_rsp_rdata, 32'hCAFE7FEF);
        else              chk($sformatf("rr%0d ldr_rsp_rdata", k),  bus.ldr_rsp_rdata,  32'hCAFE7FEF);
      end
    end

    // Reset during the response cycle of a core load drops the response
    @(negedge clk);
    bus.core_req_valid = 1'b1; bus.core_req_we = 1'b0; bus.core_req_addr = 11'h010;
    bus.core_req_size  = 2'd2;
    bus.ldr_req_valid  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.core_req_we   = 1'b1;
    bus.ldr_req_valid = 1'b1;
    bus.ldr_req_we    = 1'b1;
    #1;
    chk("rst core_rsp_valid", 32'(bus.core_rsp_valid), 32'h0);
    chk("rst core_ready",     32'(bus.core_req_ready), 32'h0);
    chk("rst ldr_ready",      32'(bus.ldr_req_ready),  32'h0);
    chk("rst mem_we",         32'(bus.mem_we),         32'h0);
    chk("rst mem_re",         32'(bus.mem_re),         32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.core_req_we = 1'b0;
    bus.ldr_req_we  = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post-rst core_rsp_valid", 32'(bus.core_rsp_valid), 32'h0);
    chk("post-rst ldr_rsp_valid",  32'(bus.ldr_rsp_valid),  32'h0);
    chk("post-rst core_ready",     32'(bus.core_req_ready), 32'h1);
    chk("post-rst ldr_ready",      32'(bus.ldr_req_ready),  32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("post-rst rsp side core", 32'(bus.core_rsp_valid), 32'h1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Sits between the pipeline's MEM stage, the boot/debug loader and the 4-lane byte-enabled data RAM (synchronous read, 1-cycle latency). Arbitrates the RAM between the two requesters round-robin. For the core it aligns store data and generates lane selects from size and offset, detects misalignment, and extracts and sign- or zero-extends load data. Throughput is one access per cycle; every accepted request gets exactly one response, one cycle later.

Parameters:
ADDR_WIDTH, 9, RAM word-address width; the core byte address is ADDR_WIDTH+2 bits.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
core_req_valid  in  1  core request present
core_req_ready  out  1  core request accepted this cycle
core_req_we  in  1  1 = store, 0 = load
core_req_addr  in  ADDR_WIDTH+2  byte address
core_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
core_req_unsigned  in  1  zero-extend load data
core_req_wdata  in  32  store data, right-justified
core_rsp_valid  out  1  response pulse
core_rsp_err  out  1  misaligned or illegal size (qualified by core_rsp_valid)
core_rsp_rdata  out  32  extended load data; 0 for stores and errors
ldr_req_valid  in  1  loader request present
ldr_req_ready  out  1  loader request accepted
ldr_req_we  in  1  loader store
ldr_req_addr  in  ADDR_WIDTH  word address
ldr_req_wstrb  in  4  loader byte strobes
ldr_req_wdata  in  32  loader store data
ldr_rsp_valid  out  1  loader response pulse
ldr_rsp_rdata  out  32  raw RAM word; 0 for stores
mem_addr  out  ADDR_WIDTH  RAM address
mem_data_in  out  32  RAM write data
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable
mem_byte_sel  out  4  RAM lane select
mem_data_out  in  32  RAM read data, valid the cycle after mem_re

Behaviour:
- Reset values: all registered outputs 0; last_grant = LDR, so the core wins the first conflict. While rst_n = 0, both ready outputs, mem_we and mem_re are forced to 0 combinationally.
- Grant (combinational, same cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - last_grant updates on every grant.
  - ready is high only for the granted requester.
  - A request is accepted when valid and ready are both high.
- mem_* are combinational from the granted request. mem_addr = core_req_addr[ADDR_WIDTH+1:2] or ldr_req_addr.
- Core lane rules, with off = addr[1:0]:
  - byte: sel = 1<<off; data = byte replicated x4.
  - half: sel = 0011 (off = 00) or 1100 (off = 10); data = half replicated x2.
  - word: sel = 1111; data = wdata.
- Core error: half with off[0] = 1, word with off != 00, or size = 11.
  - The request is still accepted (ready = 1).
  - mem_we = mem_re = 0 and mem_byte_sel = 0000.
  - Next cycle: core_rsp_valid = 1, core_rsp_err = 1, core_rsp_rdata = 0.
- Loader: mem_byte_sel = ldr_req_wstrb on stores. A store with wstrb = 0000 writes nothing but is still acknowledged.
- mem_we = accepted & we & !err; mem_re = accepted & !we & !err. On stores, mem_byte_sel drives the RAM lane enables; on loads, mem_byte_sel = 1111.
- Pending register (owner, is_load, size, off, unsigned, err) is captured on acceptance. The following cycle emits the owner's rsp_valid for exactly one cycle. Responses are in order; there is no backpressure on responses.
- Load extraction from mem_data_out:
  - byte: lane off, bit 7 sign-extended unless unsigned.
  - half: lane pair off[1], bit 15 sign-extended unless unsigned.
  - word: raw.
- Back-to-back accepts are allowed every cycle; the pending register is overwritten each cycle.
- An asynchronous reset mid-transaction clears the pending register; the in-flight response is dropped (no rsp_valid).
- Same-address store then load in consecutive cycles returns the new data (write-first RAM timing).

Test Plan:
- Core word store 0xDEADBEEF @0x010, then core unsigned byte load @0x013 -> mem_byte_sel = 1111 on the store, load rsp_rdata = 0x000000DE, rsp_valid exactly 1 cycle after accept.
- Core signed half load @0x012 after the above -> 0xFFFFDEAD; unsigned half load -> 0x0000DEAD; byte store 0x7F @0x011 -> mem_byte_sel = 0010, mem_data_in = 0x7F7F7F7F.
- Both requesters valid for 4 consecutive cycles from reset -> grants C, L, C, L; each rsp_valid pulses on the correct side one cycle after its accept.
- Core word load @0x006 -> ready = 1, mem_re = 0, next cycle core_rsp_err = 1, rdata = 0; size = 11 gives the same result; neither touches the RAM.
- Loader store wstrb = 0101, data 0x11223344 @word 5, then loader read @5 -> bytes 0 and 2 updated, ldr_rsp_rdata reflects 0x..22..44 with old bytes 1 and 3 preserved.
- Assert rst_n low in the cycle after a load accept -> no rsp_valid, ready and mem_we are 0 during reset, and the core wins the first conflict after release.
